// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, flag bit positions and MEM-stage FSM encodings
package cpu_pkg;
  localparam int WORD_W      = 16;
  localparam int ADDR_FULL_W = 32;
  localparam int FLAG_NF     = 2;
  localparam int FLAG_CF     = 1;
  localparam int FLAG_ZF     = 0;
  typedef enum logic {
    MEM_STATE_IDLE   = 1'b0,
    MEM_STATE_SECOND = 1'b1
  } mem_state_e;
endpackage

// File: rtl/data_memory.sv
// data_memory: 16-bit data RAM, one asynchronous read port, one clocked write port
//   clk      in  clock, write on rising edge
//   we       in  write enable
//   wr_addr  in  write word address
//   wr_data  in  write word
//   rd_addr  in  read word address
//   rd_data  out read word (combinational)
module data_memory
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with data memory, stack pointer and 2-cycle PC push/pop
//   clk, rst                 clock; asynchronous active-low reset
//   Valid_In                 EX/MEM holds a live instruction
//   Data, Address            store/push data (PC when Stack_PC), word address
//   MR, MW, WB, WB_Address   memory read/write, register writeback and destination
//   SP, SPOP                 stack op, 1=pop 0=push
//   Stack_PC, Stack_Flags    32-bit PC push/pop, flags pop
//   Stack_Pointer_Next       EX-computed stack pointer for single-word stack ops
//   Stack_Pointer            current stack pointer, to EX
//   Flags_From_Memory        NF|CF|ZF from the word being read on a flags pop
//   Stall                    hold the front of the pipe during the first half of a PC op
//   PC_Load, PC_Value        one-cycle pulse with the popped PC
//   WB_*_Out                 registered MEM/WB outputs
module memory_stage
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int unsigned SP_RESET = 2**ADDR_W-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Valid_In,
  input  logic [ADDR_FULL_W-1:0] Data,
  input  logic [ADDR_FULL_W-1:0] Address,
  input  logic                   MR,
  input  logic                   MW,
  input  logic                   WB,
  input  logic [2:0]             WB_Address,
  input  logic                   SP,
  input  logic                   SPOP,
  input  logic                   Stack_PC,
  input  logic                   Stack_Flags,
  input  logic [ADDR_FULL_W-1:0] Stack_Pointer_Next,
  output logic [ADDR_FULL_W-1:0] Stack_Pointer,
  output logic [2:0]             Flags_From_Memory,
  output logic                   Stall,
  output logic                   PC_Load,
  output logic [ADDR_FULL_W-1:0] PC_Value,
  output logic                   WB_Valid_Out,
  output logic                   WB_Out,
  output logic [2:0]             WB_Address_Out,
  output logic [WORD_W-1:0]      WB_Data_Out
);
  mem_state_e        state, state_next;
  logic [ADDR_W-1:0] a, cap_a, sp_q, rd_addr, wr_addr;
  logic [WORD_W-1:0] rd_data, wr_data, cap_lo, pc_lo;
  logic              cap_pop, cap_mw, cap_mr, cap_wb, we, idle, second, start;
  logic [2:0]        cap_wb_addr;
  logic              unused;
  assign unused        = ^{Address[ADDR_FULL_W-1:ADDR_W], Stack_Pointer_Next[ADDR_FULL_W-1:ADDR_W]};
  assign a             = Address[ADDR_W-1:0];
  assign idle          = state == MEM_STATE_IDLE;
  assign second        = state == MEM_STATE_SECOND;
  assign start         = idle & Valid_In & Stack_PC;
  assign Stack_Pointer = ADDR_FULL_W'(sp_q);
  // Second half of a PC op works from the captured address: push writes the low
  // word below A, pop reads the high word above A; both wrap mod the memory depth.
  always_comb begin
    state_next        = start ? MEM_STATE_SECOND : MEM_STATE_IDLE;
    Stall             = start;
    we                = rst & (second ? cap_mw : Valid_In & MW);
    wr_addr           = second ? cap_a - ADDR_W'(1) : a;
    wr_data           = second ? cap_lo : (Stack_PC ? Data[31:16] : Data[15:0]);
    rd_addr           = second ? cap_a + ADDR_W'(1) : a;
    Flags_From_Memory = (idle & Valid_In & Stack_Flags) ?
                        {rd_data[FLAG_NF], rd_data[FLAG_CF], rd_data[FLAG_ZF]} : 3'b000;
  end
  data_memory #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= MEM_STATE_IDLE;
      sp_q           <= ADDR_W'(SP_RESET);
      cap_a          <= '0;
      cap_lo         <= '0;
      cap_pop        <= 1'b0;
      cap_mw         <= 1'b0;
      cap_mr         <= 1'b0;
      cap_wb         <= 1'b0;
      cap_wb_addr    <= '0;
      pc_lo          <= '0;
      PC_Load        <= 1'b0;
      PC_Value       <= '0;
      WB_Valid_Out   <= 1'b0;
      WB_Out         <= 1'b0;
      WB_Address_Out <= '0;
      WB_Data_Out    <= '0;
    end else begin
      state   <= state_next;
      PC_Load <= second & cap_pop;
      if (start) begin
        cap_a       <= a;
        cap_lo      <= Data[15:0];
        cap_pop     <= SPOP;
        cap_mw      <= MW;
        cap_mr      <= MR;
        cap_wb      <= WB;
        cap_wb_addr <= WB_Address;
        pc_lo       <= rd_data;
      end
      if (second) begin
        sp_q           <= cap_pop ? sp_q + ADDR_W'(2) : sp_q - ADDR_W'(2);
        PC_Value       <= cap_pop ? {rd_data, pc_lo} : PC_Value;
        WB_Valid_Out   <= cap_wb;
        WB_Out         <= cap_wb;
        WB_Address_Out <= cap_wb_addr;
        WB_Data_Out    <= cap_mr ? rd_data : cap_lo;
      end else begin
        sp_q           <= (Valid_In & SP & ~Stack_PC) ? Stack_Pointer_Next[ADDR_W-1:0] : sp_q;
        WB_Valid_Out   <= Valid_In & ~Stack_PC;
        WB_Out         <= WB & ~Stack_PC;
        WB_Address_Out <= WB_Address;
        WB_Data_Out    <= MR ? rd_data : Data[15:0];
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage with a writeback scoreboard
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Valid_In, MR, MW, WB, SP, SPOP, Stack_PC, Stack_Flags;
  logic [31:0] Data, Address, Stack_Pointer_Next, Stack_Pointer, PC_Value;
  logic [2:0]  WB_Address, Flags_From_Memory, WB_Address_Out;
  logic        Stall, PC_Load, WB_Valid_Out, WB_Out;
  logic [15:0] WB_Data_Out;
  typedef struct {logic [2:0] a; logic [15:0] d;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  memory_stage #(.ADDR_W(12)) dut (
    .clk                (clk),
    .rst                (rst),
    .Valid_In           (Valid_In),
    .Data               (Data),
    .Address            (Address),
    .MR                 (MR),
    .MW                 (MW),
    .WB                 (WB),
    .WB_Address         (WB_Address),
    .SP                 (SP),
    .SPOP               (SPOP),
    .Stack_PC           (Stack_PC),
    .Stack_Flags        (Stack_Flags),
    .Stack_Pointer_Next (Stack_Pointer_Next),
    .Stack_Pointer      (Stack_Pointer),
    .Flags_From_Memory  (Flags_From_Memory),
    .Stall              (Stall),
    .PC_Load            (PC_Load),
    .PC_Value           (PC_Value),
    .WB_Valid_Out       (WB_Valid_Out),
    .WB_Out             (WB_Out),
    .WB_Address_Out     (WB_Address_Out),
    .WB_Data_Out        (WB_Data_Out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_in();
    Valid_In = 0; MR = 0; MW = 0; WB = 0; SP = 0; SPOP = 0; Stack_PC = 0; Stack_Flags = 0;
    Data = 0; Address = 0; WB_Address = 0; Stack_Pointer_Next = 0;
  endtask
  // one clock; writebacks appearing at the MEM/WB outputs are matched against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (WB_Valid_Out && WB_Out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wb_unexpected: observed addr %0d data %h expected no writeback", WB_Address_Out, WB_Data_Out);
      end else begin
        e = sb.pop_front();
        chk("wb_addr", 32'(WB_Address_Out), 32'(e.a));
        chk("wb_data", 32'(WB_Data_Out), 32'(e.d));
      end
    end
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Valid_In = 1; MW = 1; Address = a; Data = d;
    tick();
    idle_in();
  endtask
  task automatic load(input logic [31:0] a, input logic [2:0] wa, input logic [15:0] d);
    Valid_In = 1; MR = 1; WB = 1; WB_Address = wa; Address = a;
    sb.push_back('{a: wa, d: d});
    tick();
    idle_in();
  endtask
  task automatic stack_pc(input logic [31:0] a, input logic [31:0] d, input logic pop);
    Valid_In = 1; Stack_PC = 1; SP = 1; SPOP = pop; MR = pop; MW = !pop; Address = a; Data = d;
  endtask
  initial begin
    idle_in();
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", Stack_Pointer, 32'hFFF);
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_pc_load", 32'(PC_Load), 0);
    chk("rst_pc_value", PC_Value, 0);
    chk("rst_wb_valid", 32'(WB_Valid_Out), 0);
    chk("rst_wb_data", 32'(WB_Data_Out), 0);
    #3 rst = 1;
    tick();
    // store then load
    store(5, 32'h0000_1234);
    load(5, 3, 16'h1234);
    // read and write together: old word is written back, new word lands in memory
    Valid_In = 1; MR = 1; MW = 1; WB = 1; WB_Address = 1; Address = 5; Data = 32'h5555;
    sb.push_back('{a: 3'd1, d: 16'h1234});
    tick();
    idle_in();
    load(5, 2, 16'h5555);
    // invalid slot must not write
    MW = 1; Address = 5; Data = 32'h9999;
    tick();
    chk("invalid_wb_valid", 32'(WB_Valid_Out), 0);
    idle_in();
    load(5, 4, 16'h5555);
    // CALL push
    Stack_Pointer_Next = 32'hABC;
    stack_pc(32'hFFF, 32'h0001_ABCD, 0);
    #1;
    chk("call_stall_first", 32'(Stall), 1);
    tick();
    chk("call_stall_second", 32'(Stall), 0);
    chk("call_wb_valid_mid", 32'(WB_Valid_Out), 0);
    chk("call_sp_mid", Stack_Pointer, 32'hFFF);
    tick();
    idle_in();
    chk("call_sp", Stack_Pointer, 32'hFFD);
    chk("call_wb_valid_done", 32'(WB_Valid_Out), 0);
    load(32'hFFF, 0, 16'h0001);
    load(32'hFFE, 0, 16'hABCD);
    // RET pop
    stack_pc(32'hFFE, 0, 1);
    #1;
    chk("ret_stall", 32'(Stall), 1);
    tick();
    chk("ret_pc_load_mid", 32'(PC_Load), 0);
    tick();
    idle_in();
    chk("ret_pc_load", 32'(PC_Load), 1);
    chk("ret_pc_value", PC_Value, 32'h0001_ABCD);
    chk("ret_sp", Stack_Pointer, 32'hFFF);
    tick();
    chk("ret_pc_load_pulse", 32'(PC_Load), 0);
    // flags pop
    store(32'h10, 32'h0005);
    Valid_In = 1; SP = 1; SPOP = 1; MR = 1; Stack_Flags = 1; Address = 32'h10; Stack_Pointer_Next = 32'h123;
    #1;
    chk("flags_value", 32'(Flags_From_Memory), 32'b101);
    chk("flags_stall", 32'(Stall), 0);
    tick();
    idle_in();
    chk("flags_sp", Stack_Pointer, 32'h123);
    // push at address 0 wraps the low word to the top of memory
    Valid_In = 1; SP = 1; Stack_Pointer_Next = 0;
    tick();
    idle_in();
    chk("sp_zero", Stack_Pointer, 0);
    stack_pc(0, 32'hBEEF_CAFE, 0);
    tick();
    tick();
    idle_in();
    chk("wrap_push_sp", Stack_Pointer, 32'hFFE);
    load(0, 5, 16'hBEEF);
    load(32'hFFF, 6, 16'hCAFE);
    // pop at the top of memory reads its high word from address 0
    stack_pc(32'hFFF, 0, 1);
    tick();
    tick();
    idle_in();
    chk("wrap_pop_pc_load", 32'(PC_Load), 1);
    chk("wrap_pop_pc_value", PC_Value, 32'hBEEF_CAFE);
    chk("wrap_pop_sp", Stack_Pointer, 0);
    tick();
    // reset in the middle of a push
    store(32'h1F, 32'h7777);
    stack_pc(32'h20, 32'h1111_2222, 0);
    tick();
    #2 rst = 0;
    idle_in();
    #1;
    chk("abort_stall", 32'(Stall), 0);
    chk("abort_sp", Stack_Pointer, 32'hFFF);
    chk("abort_pc_load", 32'(PC_Load), 0);
    tick();
    chk("abort_wb_valid", 32'(WB_Valid_Out), 0);
    chk("abort_sp_held", Stack_Pointer, 32'hFFF);
    #3 rst = 1;
    tick();
    load(32'h1F, 7, 16'h7777);
    load(32'h20, 1, 16'h1111);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
